// File: rtl/trng_ctrl_if.sv
// Random-word delivery channel: producer drives data/valid, consumer drives ready.
// A word moves on any clock edge where valid && ready.
interface trng_ctrl_if #(
   parameter int WORD_W = 32
) ();
   logic [WORD_W-1:0] data;
   logic              valid;
   logic              ready;

   modport master (output data, output valid, input  ready);
   modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/trng_ctrl.sv
// TRNG controller: warms up the ring-oscillator combiner, decimates its bit stream into words
// and hands them out over valid/ready. Optional repetition-count health test: TRNG_HEALTH_EN.
module trng_ctrl #(
   parameter int WORD_W     = 32,
   parameter int DECIM      = 8,
   parameter int WARMUP_CYC = 64,
   parameter int RPT_LIMIT  = 32
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_start,
   input  logic         i_stop,
   input  logic         i_rand_bit,
   output logic         o_ro_enable,
   output logic         o_busy,
   output logic         o_error,
   trng_ctrl_if.master  if_out
);
   localparam int WCW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
   localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int BCW = $clog2(WORD_W + 1);

   typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_COLLECT, S_HOLD, S_FAIL} state_t;
   state_t r_state, w_next;

   logic [WCW-1:0]    r_warm;
   logic [DCW-1:0]    r_decim;
   logic [BCW-1:0]    r_bits;
   logic [WORD_W-2:0] r_shift;
   logic [WORD_W-1:0] r_data;
   logic              r_valid, r_ro_en, r_busy, r_error;

   logic              w_sample, w_last_bit, w_warm_done, w_xfer, w_rep_fail;
   logic [WORD_W-1:0] w_shifted;
   logic              w_ro_en_n, w_busy_n, w_error_n, w_valid_n;

   assign w_sample    = (r_state == S_COLLECT) && (r_decim == DCW'(DECIM - 1));
   assign w_shifted   = {r_shift, i_rand_bit};
   assign w_last_bit  = w_sample && (r_bits == BCW'(WORD_W - 1));
   assign w_warm_done = (r_warm == WCW'(WARMUP_CYC - 1));
   assign w_xfer      = r_valid && if_out.ready;

`ifdef TRNG_HEALTH_EN
   localparam int RCW = $clog2(RPT_LIMIT + 1);
   logic [RCW-1:0] r_rep, w_rep_next;
   logic           r_prev, r_rep_first;

   always_comb begin
      if (r_rep_first || (i_rand_bit != r_prev)) w_rep_next = RCW'(1);
      else                                       w_rep_next = r_rep + RCW'(1);
   end

   assign w_rep_fail = w_sample && (w_rep_next >= RCW'(RPT_LIMIT));

   // History survives HOLD; only a pass through WARMUP restarts the count.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rep       <= '0;
         r_prev      <= 1'b0;
         r_rep_first <= 1'b0;
      end else if (r_state == S_WARMUP) begin
         r_rep_first <= 1'b1;
      end else if (w_sample) begin
         r_rep       <= w_rep_next;
         r_prev      <= i_rand_bit;
         r_rep_first <= 1'b0;
      end
   end
`else
   // Health test compiled out: the limit has no effect and FAIL is unreachable.
   localparam bit RPT_CFG = (RPT_LIMIT > 0);
   assign w_rep_fail = 1'b0 & RPT_CFG;
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (i_start && !i_stop) w_next = S_WARMUP;
         S_WARMUP:  if (i_stop)             w_next = S_IDLE;
                    else if (w_warm_done)   w_next = S_COLLECT;
         S_COLLECT: if (i_stop)             w_next = S_IDLE;
                    else if (w_rep_fail)    w_next = S_FAIL;
                    else if (w_last_bit)    w_next = S_HOLD;
         S_HOLD:    if (i_stop)             w_next = S_IDLE;
                    else if (w_xfer)        w_next = S_COLLECT;
         S_FAIL:                            w_next = S_FAIL;
         default:                           w_next = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state; valid lags HOLD entry by one cycle.
   always_comb begin
      w_ro_en_n = (w_next == S_WARMUP) || (w_next == S_COLLECT) || (w_next == S_HOLD);
      w_busy_n  = (w_next != S_IDLE);
      w_error_n = (w_next == S_FAIL);
      w_valid_n = (r_state == S_HOLD) && (w_next == S_HOLD);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_ro_en <= 1'b0;
         r_busy  <= 1'b0;
         r_error <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_ro_en <= w_ro_en_n;
         r_busy  <= w_busy_n;
         r_error <= w_error_n;
         r_valid <= w_valid_n;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_warm  <= '0;
         r_decim <= '0;
         r_bits  <= '0;
         r_shift <= '0;
         r_data  <= '0;
      end else begin
         if (r_state != S_WARMUP) r_warm <= '0;
         else if (!w_warm_done)   r_warm <= r_warm + WCW'(1);

         // Outside COLLECT everything is held clear, so each word starts from scratch.
         if (r_state != S_COLLECT) begin
            r_decim <= '0;
            r_bits  <= '0;
            r_shift <= '0;
         end else begin
            r_decim <= (r_decim == DCW'(DECIM - 1)) ? '0 : r_decim + DCW'(1);
            if (w_sample) begin
               r_shift <= w_shifted[WORD_W-2:0];
               r_bits  <= r_bits + BCW'(1);
            end
         end

         if (w_last_bit && (w_next == S_HOLD)) r_data <= w_shifted;
      end
   end

   assign o_ro_enable  = r_ro_en;
   assign o_busy       = r_busy;
   assign o_error      = r_error;
   assign if_out.data  = r_data;
   assign if_out.valid = r_valid;
endmodule

// File: doc/trng_ctrl.md
Name: trng_ctrl

Overview:
- Controller that sequences the ring-oscillator combiner (`ro_comb`) used as the TRNG entropy source.
- Drives its `enable` and waits out a warm-up period that also flushes the XOR-tree pipeline.
- Decimates the combined bit stream and packs the samples into WORD_W-bit words.
- Delivers each word over a valid/ready handshake to the consumer.

Parameters:
- WORD_W, 32: width of the output random word. Must be ≥ 2.
- DECIM, 8: clock cycles per sampled bit. Must be ≥ 1.
- WARMUP_CYC, 64: cycles `ro_enable` is high before sampling starts. Must be ≥ `LOG_NUM_OF_RO`+2.
- RPT_LIMIT, 32: consecutive identical sampled bits that declare a stuck source. Used only with the optional feature.

Ports:
- clock, input, 1: single system clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle request to begin generation. Honoured only in IDLE.
- stop, input, 1: request to halt. Honoured in any state except FAIL.
- rand_bit, input, 1: combined entropy bit from `ro_comb` `output_comb`.
- ro_enable, output, 1: drives `ro_comb` `enable`.
- data_out, output, WORD_W: packed random word. Stable while valid=1.
- valid, output, 1: data_out holds a complete word.
- ready, input, 1: consumer accepts data_out when valid && ready.
- busy, output, 1: high in every state except IDLE.
- error, output, 1: health-test failure flag (optional feature).

Behaviour:
- Clocking and reset:
  - One clock. reset is synchronous and active-high, sampled on the clock edge.
  - Reset values: state=IDLE, ro_enable=0, valid=0, data_out=0, busy=0, error=0, all counters and the shift register = 0.
- States: IDLE, WARMUP, COLLECT, HOLD, FAIL. All outputs are registered.
- IDLE:
  - ro_enable=0, valid=0.
  - start=1 → WARMUP; warm counter cleared.
- WARMUP:
  - ro_enable=1.
  - Counts WARMUP_CYC cycles; on the last one → COLLECT with the decim and bit counters cleared.
  - rand_bit is ignored.
- COLLECT:
  - ro_enable=1. The decim counter runs 0..DECIM-1 and wraps.
  - When it equals DECIM-1, rand_bit is captured: shift register shifts left, new bit enters bit 0, bit counter increments.
  - On the capture that completes WORD_W bits: data_out ← shifted value, valid ← 1, → HOLD.
- HOLD:
  - ro_enable stays 1. No sampling; rand_bit is discarded.
  - valid && ready → valid=0 next cycle, → COLLECT with counters cleared. The next word is fully fresh; no bits are carried over.
- Latency: the first valid rises exactly WARMUP_CYC + WORD_W·DECIM + 1 cycles after the edge that sampled start=1.
- stop:
  - In WARMUP/COLLECT/HOLD: → IDLE next cycle, ro_enable=0, valid=0, partial word discarded.
  - An unaccepted word in HOLD is dropped. If ready and stop are high together in HOLD, the transfer counts as done and the state still goes to IDLE.
- start and stop in the same cycle in IDLE: stop wins; remain in IDLE.
- start outside IDLE is ignored.
- Reset mid-operation: returns to IDLE within one cycle regardless of state, including FAIL.
- data_out holds its last value after valid drops; it is only cleared by reset.

Optional Feature:
- Macro: TRNG_HEALTH_EN.
- When defined, a repetition-count test runs on sampled bits in COLLECT:
  - The counter resets to 1 on a bit differing from the previous sample, else increments.
  - The first sample after entering COLLECT from WARMUP starts the count at 1.
  - When the count reaches RPT_LIMIT: → FAIL next cycle, error=1, ro_enable=0, valid=0, the word in progress is discarded.
  - FAIL is exited only by reset; start and stop are ignored.
  - The repetition history persists across HOLD.
- When undefined: no repetition counter is built, error is tied to 0, and FAIL is unreachable.

Test Plan:
- WORD_W=8, DECIM=4, WARMUP_CYC=16, rand_bit pattern 1,0,1,1,0,0,1,0 on successive sample cycles, ready=1 → valid high exactly 49 cycles after start, data_out=8'hB2, ro_enable high from the cycle after start.
- Same config, ready=0 for 20 cycles after valid → data_out stable at its value and valid held for all 20 cycles; after ready=1, valid drops, next word valid 33 cycles after the transfer.
- stop asserted mid-COLLECT (bit 5 of 8) → IDLE next cycle, ro_enable=0, busy=0. A restart yields a full fresh word after 49 cycles.
- start and stop high together in IDLE → remains IDLE, ro_enable stays 0; start alone with reset asserted the same cycle → IDLE.
- TRNG_HEALTH_EN defined, RPT_LIMIT=5, rand_bit held at 1 → error=1 and ro_enable=0 the cycle after the 5th identical sample; start ignored; reset clears error=0.
- TRNG_HEALTH_EN undefined, rand_bit held at 0 → error stays 0, valid with data_out=8'h00 at cycle 49.
